// File: rtl/cache_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_arbiter_if
//   Bundle of every signal between the I-cache, the D-cache, the shared
//   physical memory and the arbiter that sits between them.
//
//   Ports / signals:
//     i_pmem_read, i_pmem_address          I-cache line-fill request
//     i_pmem_rdata, i_pmem_resp            fill data / completion to I-cache
//     d_pmem_read, d_pmem_write            D-cache fill / write-back request
//     d_pmem_address, d_pmem_wdata         D-cache address / write-back data
//     d_pmem_rdata, d_pmem_resp            fill data / completion to D-cache
//     pmem_read, pmem_write                shared memory strobes
//     pmem_address, pmem_wdata             shared memory command
//     pmem_rdata, pmem_resp                shared memory return path
//
//   Modports:
//     master : the arbiter itself (masters the shared memory, serves caches)
//     slave  : the environment around it (caches + memory)
// ---------------------------------------------------------------------------
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//   Shares one physical memory port between an I-cache and a D-cache.
//   One transaction is in flight at a time. Requests are sampled only in
//   IDLE; a tie is broken round-robin against the last grant (reset leaves
//   last grant = I so the D-cache wins the first tie). On grant the address,
//   operation and (for write-backs) data are captured in command registers
//   which alone drive the memory side until pmem_resp is seen.
//
//   Ports:
//     clk  : sole clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : cache_arbiter_if.master (cache requests, memory command/return)
// ---------------------------------------------------------------------------
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  cache_arbiter_if.master  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]        state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              cmd_read_q,   cmd_read_d;
  logic              cmd_write_q,  cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q,   cmd_addr_d;
  logic [LINE_W-1:0] cmd_wdata_q,  cmd_wdata_d;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  // Grant decision, only meaningful in IDLE.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through the block leaves it unassigned and no latch is inferred.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
        // Tie: serve whoever was not served last.
        grant_d = (last_grant_q == GRANT_I);
        grant_i = ~grant_d;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_read_d   = cmd_read_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = D_BUSY;
          last_grant_d = GRANT_D;
          cmd_addr_d   = bus.d_pmem_address;
          // Write wins over read so a dirty victim is written back
          // before the fill that replaces it.
          cmd_write_d  = bus.d_pmem_write;
          cmd_read_d   = ~bus.d_pmem_write;
          if (bus.d_pmem_write) begin
            cmd_wdata_d = bus.d_pmem_wdata;
          end
        end else if (grant_i) begin
          state_d      = I_BUSY;
          last_grant_d = GRANT_I;
          cmd_addr_d   = bus.i_pmem_address;
          cmd_read_d   = 1'b1;
          cmd_write_d  = 1'b0;
        end
      end

      I_BUSY, D_BUSY: begin
        // The requester may drop its request; only pmem_resp ends the
        // transaction. Strobes fall together with the return to IDLE.
        if (bus.pmem_resp) begin
          state_d     = IDLE;
          cmd_read_d  = 1'b0;
          cmd_write_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_read_d  = 1'b0;
        cmd_write_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wide command registers are reset too, because the memory
      // side must show address and data as zero until the first grant.
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      cmd_read_q   <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_read_q   <= cmd_read_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
    end
  end

  assign bus.pmem_read    = cmd_read_q;
  assign bus.pmem_write   = cmd_write_q;
  assign bus.pmem_address = cmd_addr_q;
  assign bus.pmem_wdata   = cmd_wdata_q;

  // Completion is steered to the owner in the same cycle; a response that
  // arrives while IDLE belongs to nobody and is dropped.
  assign bus.i_pmem_resp  = bus.pmem_resp & (state_q == I_BUSY);
  assign bus.d_pmem_resp  = bus.pmem_resp & (state_q == D_BUSY);

  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule
